// File: rtl/seven_seg_pkg.sv
// Shared constants and the BCD-to-segment decode used by the 7-segment scanner.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package seven_seg_pkg;

    localparam int BCD_W = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] DIGIT_PATTERNS [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // Non-decimal codes 10..15 render as a dark digit rather than garbage.
    function automatic logic [6:0] decode_bcd(input logic [BCD_W-1:0] value);
        if (value < 4'd10) begin
            return DIGIT_PATTERNS[value];
        end
        return SEG_BLANK;
    endfunction

endpackage

// File: rtl/scan_timebase.sv
// Digit-slot timebase: tick counts cycles within a slot, idx selects the digit.
// frame_end marks the last cycle of the last slot, where the display may commit.
module scan_timebase #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             tick_blank,
    output logic [IDX_W-1:0] idx,
    output logic             frame_end
);

    localparam int TICK_W = $clog2(REFRESH_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(REFRESH_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_BLANK = TICK_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [TICK_W-1:0] tick;
    logic              tick_last;

    assign tick_last  = (tick == TICK_LAST);
    assign tick_blank = (tick < TICK_BLANK);
    assign frame_end  = tick_last && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick <= '0;
            idx  <= '0;
        end else if (tick_last) begin
            tick <= '0;
            idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            tick <= tick + 1'b1;
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed N-digit 7-segment driver with frame-synchronous double buffering,
// anode blanking gap for ghost suppression and optional leading-zero blanking.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BCD_W*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]       dp_in,
    input  logic                        load,
    input  logic                        blank_lz,
    output logic [6:0]                  seg_out,
    output logic                        dp_out,
    output logic [NUM_DIGITS-1:0]       an_out,
    output logic                        frame_done,
    output logic                        load_ack
);

    localparam int DIG_W = BCD_W * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic             tick_blank;
    logic [IDX_W-1:0] idx;
    logic             frame_end;

    scan_timebase #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES),
        .IDX_W       (IDX_W)
    ) u_timebase (
        .clk       (clk),
        .rst       (rst),
        .tick_blank(tick_blank),
        .idx       (idx),
        .frame_end (frame_end)
    );

    logic [DIG_W-1:0]      disp_digits, pend_digits;
    logic [NUM_DIGITS-1:0] disp_dp, pend_dp;
    logic                  pend_valid;

    // A load on the boundary cycle bypasses the pending stage so it is never
    // lost and never committed twice.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_digits <= '0;
            disp_dp     <= '0;
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_valid  <= 1'b0;
            load_ack    <= 1'b0;
        end else if (frame_end) begin
            load_ack <= load || pend_valid;
            if (load) begin
                disp_digits <= digits_in;
                disp_dp     <= dp_in;
            end else if (pend_valid) begin
                disp_digits <= pend_digits;
                disp_dp     <= pend_dp;
            end
            pend_valid <= 1'b0;
        end else begin
            load_ack <= 1'b0;
            if (load) begin
                pend_digits <= digits_in;
                pend_dp     <= dp_in;
                pend_valid  <= 1'b1;
            end
        end
    end

    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  zero_run;
    logic [BCD_W-1:0]      cur_digit;
    logic [NUM_DIGITS-1:0] an_next;

    // zero_run stays set only while every digit from the top down is zero.
    always_comb begin
        lz_mask  = '0;
        zero_run = blank_lz;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run && (disp_digits[i*BCD_W +: BCD_W] == '0);
            lz_mask[i] = zero_run;
        end
    end

    always_comb begin
        cur_digit    = disp_digits[int'(idx)*BCD_W +: BCD_W];
        an_next      = '1;
        an_next[idx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_out    <= SEG_BLANK;
            dp_out     <= 1'b1;
            an_out     <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (tick_blank) begin
                seg_out <= SEG_BLANK;
                dp_out  <= 1'b1;
                an_out  <= '1;
            end else begin
                seg_out <= lz_mask[idx] ? SEG_BLANK : decode_bcd(cur_digit);
                dp_out  <= ~disp_dp[idx];
                an_out  <= an_next;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: cycle-level reference model feeds a scoreboard queue,
// a negedge monitor compares every registered output word, plus targeted spot checks.
module tb_seven_seg_scanner;

    localparam int N = 4;
    localparam int R = 4;
    localparam int B = 1;
    localparam int FRAME = R * N;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [4*N-1:0] digits_in = '0;
    logic [N-1:0]   dp_in = '0;
    logic           load = 1'b0;
    logic           blank_lz = 1'b0;
    logic [6:0]     seg_out;
    logic           dp_out;
    logic [N-1:0]   an_out;
    logic           frame_done;
    logic           load_ack;

    int tests = 0;
    int fails = 0;

    seven_seg_scanner #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .BLANK_CYCLES(B)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .load      (load),
        .blank_lz  (blank_lz),
        .seg_out   (seg_out),
        .dp_out    (dp_out),
        .an_out    (an_out),
        .frame_done(frame_done),
        .load_ack  (load_ack)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Word layout: {seg[6:0], dp, an[3:0], frame_done, load_ack}
    logic [13:0] exp_q[$];
    int          model_p = 0;
    int          disp_d[N];
    int          disp_p[N];
    int          pend_d[N];
    int          pend_p[N];
    bit          pend_flag = 0;

    function automatic logic [6:0] ref_seg(input int v);
        case (v)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            model_p   = 0;
            pend_flag = 0;
            for (int i = 0; i < N; i++) begin
                disp_d[i] = 0; disp_p[i] = 0; pend_d[i] = 0; pend_p[i] = 0;
            end
            exp_q.push_back({7'h7F, 1'b1, 4'hF, 1'b0, 1'b0});
        end else begin
            int       tick, slot, top_nz;
            bit       boundary, ack;
            logic [6:0] s;
            logic       d;
            logic [N-1:0] a;
            tick     = model_p % R;
            slot     = (model_p / R) % N;
            boundary = (model_p % FRAME) == FRAME - 1;
            top_nz   = -1;
            for (int i = 0; i < N; i++) if (disp_d[i] != 0) top_nz = i;
            if (tick < B) begin
                s = 7'h7F; d = 1'b1; a = '1;
            end else begin
                a = ~(N'(1) << slot);
                d = ~disp_p[slot][0];
                if (blank_lz && slot != 0 && slot > top_nz) s = 7'h7F;
                else s = ref_seg(disp_d[slot]);
            end
            ack = 0;
            if (boundary && (load || pend_flag)) begin
                ack = 1;
                for (int i = 0; i < N; i++) begin
                    disp_d[i] = load ? int'(digits_in[4*i +: 4]) : pend_d[i];
                    disp_p[i] = load ? int'(dp_in[i]) : pend_p[i];
                end
                pend_flag = 0;
            end else if (!boundary && load) begin
                for (int i = 0; i < N; i++) begin
                    pend_d[i] = int'(digits_in[4*i +: 4]);
                    pend_p[i] = int'(dp_in[i]);
                end
                pend_flag = 1;
            end
            exp_q.push_back({s, d, a, boundary, ack});
            model_p++;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [13:0] e, g;
            e = exp_q.pop_front();
            g = {seg_out, dp_out, an_out, frame_done, load_ack};
            tests++;
            if (g !== e) begin
                fails++;
                $display("FAIL scan_word t=%0t: got seg=%h dp=%b an=%b fd=%b ack=%b, expected seg=%h dp=%b an=%b fd=%b ack=%b",
                         $time, g[13:7], g[6], g[5:2], g[1], g[0],
                         e[13:7], e[6], e[5:2], e[1], e[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
        digits_in = d;
        dp_in     = p;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
    endtask

    // Returns at a negedge where the next posedge is frame position ph.
    task automatic wait_phase(input int ph);
        int n = 0;
        @(negedge clk);
        while ((model_p % FRAME) != ph && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_phase_reached", 16'(model_p % FRAME), 16'(ph));
    endtask

    task automatic wait_an(input logic [3:0] want, input string name);
        int n = 0;
        while (an_out !== want && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 16'(an_out), 16'(want));
    endtask

    task automatic wait_ack();
        int n = 0;
        while (load_ack !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("load_ack_seen", 16'(load_ack), 16'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        cycles(3);
        check("reset_seg", 16'(seg_out), 16'h7F);
        check("reset_an", 16'(an_out), 16'hF);
        rst = 1'b0;

        // Basic load: shown only after the first frame boundary.
        pulse_load(16'h1234, 4'b0000);
        wait_ack();
        wait_an(4'b1110, "an_slot0_1234");
        check("seg_digit0_is_4", 16'(seg_out), 16'h19);
        wait_an(4'b0111, "an_slot3_1234");
        check("seg_digit3_is_1", 16'(seg_out), 16'h79);
        cycles(20);

        // Two loads in one frame: last one wins, one ack.
        wait_phase(0);
        pulse_load(16'h1111, 4'b0000);
        cycles(3);
        pulse_load(16'h5678, 4'b0000);
        cycles(40);

        // Load on the boundary cycle itself.
        wait_phase(FRAME - 1);
        pulse_load(16'h9999, 4'b0000);
        check("boundary_load_ack", 16'(load_ack), 16'd1);
        cycles(40);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        pulse_load(16'h0040, 4'b0000);
        cycles(40);
        pulse_load(16'h0000, 4'b0000);
        cycles(40);
        blank_lz = 1'b0;

        // Non-BCD digit and decimal point.
        pulse_load(16'h12B4, 4'b0001);
        cycles(40);

        // Reset during slot 2 with pending data outstanding.
        wait_phase(0);
        pulse_load(16'h7777, 4'b1111);
        wait_phase(2 * R + 2);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_an", 16'(an_out), 16'hF);
        check("midreset_seg", 16'(seg_out), 16'h7F);
        rst = 1'b0;
        @(negedge clk);
        check("restart_blank_edge1", 16'(an_out), 16'hF);
        @(negedge clk);
        check("restart_lit_edge2", 16'(an_out), 16'hE);
        check("restart_digit0_zero", 16'(seg_out), 16'h40);
        cycles(40);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            blank_lz  = ($urandom_range(0, 3) != 0);
            load      = ($urandom_range(0, 5) == 0);
            digits_in = 16'($urandom);
            dp_in     = 4'($urandom);
            rst       = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        load = 1'b0;
        rst  = 1'b0;
        cycles(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
